// File: rtl/axi_arb_mon.sv
// Passive monitor for an AXI address-channel arbiter: checks every grant against
// the selected arbitration policy and reports registered, sticky and counted violations.
module axi_arb_mon #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16,
  parameter int ECNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arb_en,
  input  logic [1:0]                  arb_mode,
  input  logic [NUM_CH*CNT_W-1:0]     weight,
  input  logic [NUM_CH-1:0]           valid,
  input  logic [NUM_CH-1:0]           ready,
  input  logic                        clr,
  output logic [4:0]                  err_pulse,
  output logic [4:0]                  err_sticky,
  output logic [ECNT_W-1:0]           err_cnt,
  output logic [$clog2(NUM_CH)-1:0]   last_ch
);

  localparam int LW = $clog2(NUM_CH);

  function automatic logic [CNT_W-1:0] sat_inc_run(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ECNT_W-1:0] sat_inc_err(input logic [ECNT_W-1:0] v);
    return (&v) ? v : v + ECNT_W'(1);
  endfunction

  logic [NUM_CH-1:0] suc;
  logic [NUM_CH-1:0] lower_mask;
  logic [NUM_CH-1:0] between_mask;
  logic [NUM_CH-1:0] others_mask;
  logic [LW-1:0]     gidx;
  logic              any_suc;
  logic              multi;
  logic [CNT_W-1:0]  thr;
  logic [CNT_W-1:0]  run_cnt;
  logic [4:0]        err_next;
  logic [1:0]        mode_q;
  logic              en_q;
  int                n_suc;
  int                off_g;
  int                off_i;

  always_comb begin
    suc          = valid & ready;
    gidx         = '0;
    any_suc      = 1'b0;
    n_suc        = 0;
    lower_mask   = '0;
    between_mask = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (suc[i]) begin
        gidx    = LW'(i);
        any_suc = 1'b1;
        n_suc   = n_suc + 1;
      end
    end
    multi = (n_suc > 1);

    // Cyclic distance from last_ch; a repeat grant to last_ch spans the whole ring.
    off_g = int'(gidx) - int'(last_ch);
    if (off_g <= 0) off_g = off_g + NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      off_i = i - int'(last_ch);
      if (off_i < 0) off_i = off_i + NUM_CH;
      between_mask[i] = (off_i != 0) && (off_i < off_g);
      lower_mask[i]   = (i < int'(gidx));
    end
    others_mask = valid & ~(NUM_CH'(1) << gidx);

    thr = weight[int'(gidx)*CNT_W +: CNT_W];
    if (thr == '0) thr = CNT_W'(1);

    err_next    = '0;
    err_next[0] = multi;
    err_next[1] = !arb_en && |(suc >> 1);
    if (arb_en && any_suc) begin
      case (arb_mode)
        2'd0: err_next[2] = |(valid & lower_mask);
        2'd1: err_next[3] = |(valid & between_mask);
        2'd2: begin
          if (gidx != last_ch) err_next[3] = |(valid & between_mask);
          else                 err_next[4] = (run_cnt >= thr) && |others_mask;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= arb_mode;
    en_q   <= arb_en;
  end

  // Registered report stage: pulse, sticky and count all reflect the same grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      err_cnt    <= '0;
      last_ch    <= LW'(NUM_CH - 1);
      run_cnt    <= '0;
    end else begin
      err_pulse  <= err_next;
      err_sticky <= (clr ? 5'b0 : err_sticky) | err_next;
      if (err_next != 5'b0)  err_cnt <= sat_inc_err(clr ? '0 : err_cnt);
      else if (clr)          err_cnt <= '0;
      if (any_suc) last_ch <= gidx;
      if ((mode_q != arb_mode) || (en_q != arb_en)) run_cnt <= '0;
      else if (arb_en && (arb_mode == 2'd2) && any_suc)
        run_cnt <= (gidx != last_ch) ? CNT_W'(1) : sat_inc_run(run_cnt);
    end
  end

endmodule

// File: doc/axi_arb_mon.md
AXI_ARB_MON -- requirements
Module: axi_arb_mon

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of arbitrated AXI address channels (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of per-channel weight and run counter.
REQ-003 SHALL have parameter ECNT_W, default 16, width of saturating error counter.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port arb_en  input  1  arbiter enable; 0 means channel 0 pass-through only.
REQ-007 SHALL have port arb_mode  input  2  0 fixed priority, 1 round robin, 2 weighted round robin, 3 reserved.
REQ-008 SHALL have port weight  input  NUM_CH*CNT_W  per-channel grant quota, channel i in bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port valid  input  NUM_CH  per-channel awvalid or arvalid.
REQ-010 SHALL have port ready  input  NUM_CH  per-channel awready or arready.
REQ-011 SHALL have port clr  input  1  one-cycle clear of sticky flags and error counter.
REQ-012 SHALL have port err_pulse  output  5  registered per-check violation pulse: bit0 multi, bit1 noarb, bit2 prio, bit3 rr, bit4 wgt.
REQ-013 SHALL have port err_sticky  output  5  sticky OR of err_pulse since last rst or clr.
REQ-014 SHALL have port err_cnt  output  ECNT_W  saturating count of cycles with any err_pulse bit set.
REQ-015 SHALL have port last_ch  output  $clog2(NUM_CH)  index of most recently granted channel.

Function
REQ-016 SHALL define suc[i] = valid[i] & ready[i]; a grant is any cycle with suc[i]=1.
REQ-017 SHALL flag multi when more than one suc bit is set in the same cycle, in every mode.
REQ-018 SHALL flag noarb when arb_en=0 and suc[i]=1 for any i != 0; mode checks are disabled while arb_en=0.
REQ-019 SHALL, in mode 0, flag prio on suc[j] while valid[i]=1 for any i<j.
REQ-020 SHALL, in mode 1, flag rr on suc[j] while valid[i]=1 for any i strictly between last_ch and j in cyclic order (last_ch+1 .. j-1 mod NUM_CH).
REQ-021 SHALL, in mode 2, keep run_cnt: set to 1 on a grant to a channel != last_ch, increment (saturating at all-ones) on a grant to last_ch.
REQ-022 SHALL, in mode 2, flag wgt on suc[j] with j==last_ch, run_cnt >= max(weight[j],1), and valid[i]=1 for some i != j.
REQ-023 SHALL, in mode 2, flag rr-order violations on channel switches using the REQ-020 rule.
REQ-024 SHALL perform only the multi check in mode 3.
REQ-025 SHALL assert each err_pulse bit exactly one cycle after the offending grant cycle, for one cycle.
REQ-026 SHALL update last_ch on every grant; on a multi-grant cycle, update it to the lowest granted index and evaluate mode checks against that index only.
REQ-027 SHALL clear run_cnt to 0, keeping last_ch, in the cycle after arb_mode or arb_en changes value.
REQ-028 SHALL increment err_cnt by 1 per cycle with err_pulse != 0 and hold it at all-ones on saturation.
REQ-029 SHALL give a new err_pulse priority over clr in the same cycle: the sticky bit is set and err_cnt is 1.

Reset
REQ-030 SHALL, while rst=1, drive err_pulse=0, err_sticky=0, err_cnt=0, last_ch=NUM_CH-1 and run_cnt=0, with the first post-reset grant evaluated from channel 0 onward.
REQ-031 SHALL abandon any in-flight check when rst is asserted mid-operation, with no err_pulse in the cycle after reset release.

Verification
REQ-032 Mode 0, NUM_CH=3: valid=3'b011, suc[1] -> err_pulse=5'b00100 next cycle, err_cnt=1.
REQ-033 Mode 1: grants 0,1,2,0 with all valid held -> no errors; grant 0 then 2 while valid[1]=1 -> rr pulse, last_ch=2.
REQ-034 Mode 2, weight0=3, all valid: 3 consecutive grants to ch0 -> clean; a 4th grant to ch0 -> wgt pulse; weight0=0 behaves as 1.
REQ-035 arb_en=0, suc[2]=1 -> noarb pulse; suc[0]=suc[1]=1 in one cycle -> multi pulse, last_ch=0.
REQ-036 clr in the same cycle as a new violation -> sticky retains only the new bit, err_cnt=1; ECNT_W=2 with 5 violations -> err_cnt=3.
REQ-037 rst asserted mid-run in mode 2 -> all outputs 0, last_ch=NUM_CH-1; NUM_CH=5 round-robin wrap 4->0 -> clean.
